usb_rx_conditioner: RTL



---
 rtl/usb_rx_conditioner_if.sv | 20 ++
 rtl/usb_rx_conditioner.sv | 93 +++++++++
 2 files changed

// File: rtl/usb_rx_conditioner_if.sv
// usb_rx_conditioner_if: pad-side inputs and conditioned outputs of the USB receive conditioner
interface usb_rx_conditioner_if;
    logic       usb_p_rx_io;
    logic       usb_n_rx_io;
    logic       usb_tx_en;
    logic       usb_p_rx;
    logic       usb_n_rx;
    logic [1:0] line_state;
    logic       bus_reset;
    logic       usb_pu;
    logic       activity;
    modport master (
        output usb_p_rx_io, usb_n_rx_io, usb_tx_en,
        input  usb_p_rx, usb_n_rx, line_state, bus_reset, usb_pu, activity
    );
    modport slave (
        input  usb_p_rx_io, usb_n_rx_io, usb_tx_en,
        output usb_p_rx, usb_n_rx, line_state, bus_reset, usb_pu, activity
    );
endinterface

// File: rtl/usb_rx_conditioner.sv
// usb_rx_conditioner: pad sync, TX echo mask, bus-reset detect, pull-up delay, activity strobe; USB_SE1_FILTER_EN holds output on SE1
module usb_rx_conditioner #(
    parameter int SYNC_STAGES      = 2,
    parameter int SE0_RESET_CYCLES = 120,
    parameter int PU_DELAY_CYCLES  = 48000,
    parameter int ACT_CYCLES       = 2400000
) (
    input  logic                 clk_48mhz,
    input  logic                 reset,
    usb_rx_conditioner_if.slave  bus
);
    localparam int HW = $clog2(SYNC_STAGES + 2);
    localparam int SW = $clog2(SE0_RESET_CYCLES + 1);
    localparam int PW = $clog2(PU_DELAY_CYCLES + 1);
    localparam int AW = $clog2(ACT_CYCLES + 1);
`ifdef USB_SE1_FILTER_EN
    localparam bit SE1_FILTER = 1'b1;
`else
    localparam bit SE1_FILTER = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, COUNT, FIRED} se0_state_t;
    typedef enum logic {PU_WAIT, PU_ON} pu_state_t;
    logic [SYNC_STAGES-1:0] sync_p_q, sync_p_d, sync_n_q, sync_n_d;
    logic                   out_p_q, out_p_d, out_n_q, out_n_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic                   se1_q, se1_d;
    se0_state_t             se0_state_q, se0_state_d;
    logic [SW-1:0]          se0_cnt_q, se0_cnt_d, se0_inc;
    pu_state_t              pu_state_q, pu_state_d;
    logic [PW-1:0]          pu_cnt_q, pu_cnt_d;
    logic [AW-1:0]          act_cnt_q, act_cnt_d;
    logic                   masked, se1_in, se0, bus_rst;
    // Synchronizer shift, TX holdoff, output register select and activity stretch
    always_comb begin
        sync_p_d  = {sync_p_q[SYNC_STAGES-2:0], bus.usb_p_rx_io};
        sync_n_d  = {sync_n_q[SYNC_STAGES-2:0], bus.usb_n_rx_io};
        masked    = bus.usb_tx_en || hold_q != '0;
        hold_d    = bus.usb_tx_en ? HW'(SYNC_STAGES + 1) : hold_q != '0 ? hold_q - 1'b1 : hold_q;
        se1_in    = SE1_FILTER && sync_p_q[SYNC_STAGES-1] && sync_n_q[SYNC_STAGES-1];
        out_p_d   = masked ? 1'b1 : se1_in ? out_p_q : sync_p_q[SYNC_STAGES-1];
        out_n_d   = masked ? 1'b0 : se1_in ? out_n_q : sync_n_q[SYNC_STAGES-1];
        se1_d     = !masked && se1_in;
        act_cnt_d = (!masked && {out_p_d, out_n_d} != {out_p_q, out_n_q}) ? AW'(ACT_CYCLES)
                  : act_cnt_q != '0 ? act_cnt_q - 1'b1 : act_cnt_q;
    end
    // SE0 run detector: one pulse per run, counter frozen once fired
    always_comb begin
        se0         = !out_p_q && !out_n_q && !se1_q;
        se0_inc     = (se0_state_q == COUNT ? se0_cnt_q : '0) + 1'b1;
        bus_rst     = se0 && se0_state_q != FIRED && se0_inc == SW'(SE0_RESET_CYCLES);
        se0_state_d = !se0 ? IDLE : (bus_rst || se0_state_q == FIRED) ? FIRED : COUNT;
        se0_cnt_d   = !se0 ? '0 : se0_state_q == FIRED ? se0_cnt_q : se0_inc;
    end
    // Pull-up connect delay after reset
    always_comb begin
        pu_state_d = (pu_state_q == PU_WAIT && pu_cnt_q == PW'(PU_DELAY_CYCLES - 1)) ? PU_ON : pu_state_q;
        pu_cnt_d   = (pu_state_q == PU_WAIT && pu_state_d == PU_WAIT) ? pu_cnt_q + 1'b1 : pu_cnt_q;
    end
    // State registers; sync chains and outputs preset to J
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            sync_p_q    <= '1;
            sync_n_q    <= '0;
            out_p_q     <= 1'b1;
            out_n_q     <= 1'b0;
            hold_q      <= '0;
            se1_q       <= 1'b0;
            se0_state_q <= IDLE;
            se0_cnt_q   <= '0;
            pu_state_q  <= PU_WAIT;
            pu_cnt_q    <= '0;
            act_cnt_q   <= '0;
        end else begin
            sync_p_q    <= sync_p_d;
            sync_n_q    <= sync_n_d;
            out_p_q     <= out_p_d;
            out_n_q     <= out_n_d;
            hold_q      <= hold_d;
            se1_q       <= se1_d;
            se0_state_q <= se0_state_d;
            se0_cnt_q   <= se0_cnt_d;
            pu_state_q  <= pu_state_d;
            pu_cnt_q    <= pu_cnt_d;
            act_cnt_q   <= act_cnt_d;
        end
    end
    assign bus.usb_p_rx   = out_p_q;
    assign bus.usb_n_rx   = out_n_q;
    assign bus.line_state = {out_p_q, out_n_q};
    assign bus.bus_reset  = bus_rst;
    assign bus.usb_pu     = pu_state_q == PU_ON;
    assign bus.activity   = act_cnt_q != '0;
endmodule
